// File: rtl/count_sequencer.sv
// Purpose: run controller that gates the counter datapath with a clear strobe and a periodic count enable.
// Latency: all outputs registered; commands sampled at an edge take effect on the outputs one cycle later.
// Backpressure: none; start/stop/step are single-cycle strobes, and any strobe not valid in the current state is dropped.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous reset, active low
//   start   - begin a run from IDLE/DONE (latches div/len), resume from PAUSE
//   stop    - RUN -> PAUSE, PAUSE/DONE -> IDLE; highest priority
//   step    - in PAUSE only: issue a single enable pulse
//   div     - tick period minus one (period = div+1 cycles)
//   len     - enable pulses per run, 0 = free-run
//   cnt_clr - one-cycle clear to the counter datapath at run start
//   cnt_en  - one-cycle count enable to the counter datapath
//   busy    - high in RUN or PAUSE
//   done    - high in DONE
//   state   - IDLE=00, RUN=01, PAUSE=10, DONE=11
//   pulses  - cnt_en pulses issued since the last clear
module count_sequencer #(
    parameter int DIV_W = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic [DIV_W-1:0] div,
    input  logic [LEN_W-1:0] len,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state,
    output logic [LEN_W-1:0] pulses
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           state_q, state_n;
    logic [DIV_W-1:0] psc_q, psc_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic [LEN_W-1:0] len_q, len_n;
    logic [LEN_W-1:0] pulses_q, pulses_n;
    logic [LEN_W-1:0] pulses_inc;
    logic             launch;
    logic             pulse;
    logic             tick;

    // Free-run wraps naturally through the LEN_W-bit adder.
    assign pulses_inc = pulses_q + LEN_W'(1);
    assign tick       = (psc_q == div_q);

    always_comb begin
        state_n  = state_q;
        psc_n    = psc_q;
        div_n    = div_q;
        len_n    = len_q;
        pulses_n = pulses_q;
        launch   = 1'b0;
        pulse    = 1'b0;

        case (state_q)
            IDLE: begin
                // stop is meaningless in IDLE, so it does not mask start here.
                if (start) begin
                    launch = 1'b1;
                end
            end
            RUN: begin
                // stop wins over a tick on the same edge: prescaler and
                // pulse count freeze so the phase survives the pause.
                if (stop) begin
                    state_n = PAUSE;
                end else if (tick) begin
                    psc_n = '0;
                    pulse = 1'b1;
                end else begin
                    psc_n = psc_q + DIV_W'(1);
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (start) begin
                    state_n = RUN;
                end else if (step) begin
                    pulse = 1'b1;
                end
            end
            DONE: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (start) begin
                    launch = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (launch) begin
            div_n    = div;
            len_n    = len;
            pulses_n = '0;
            psc_n    = '0;
            state_n  = RUN;
        end

        // Shared by RUN ticks and PAUSE steps: the pulse that reaches the
        // programmed length moves to DONE on the same edge, so done and
        // the final cnt_en rise together.
        if (pulse) begin
            pulses_n = pulses_inc;
            if ((len_q != '0) && (pulses_inc == len_q)) begin
                state_n = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            psc_q    <= '0;
            div_q    <= '0;
            len_q    <= '0;
            pulses_q <= '0;
            cnt_clr  <= 1'b0;
            cnt_en   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_n;
            psc_q    <= psc_n;
            div_q    <= div_n;
            len_q    <= len_n;
            pulses_q <= pulses_n;
            cnt_clr  <= launch;
            cnt_en   <= pulse;
            busy     <= (state_n == RUN) || (state_n == PAUSE);
            done     <= (state_n == DONE);
        end
    end

    assign state  = state_q;
    assign pulses = pulses_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: scenario tasks plus a randomized soak, each cycle compared against a cycles-remaining reference model.
module tb_count_sequencer;
    localparam int DIV_W = 4;
    localparam int LEN_W = 8;
    localparam int VW    = 6 + LEN_W;

    logic             clk   = 1'b0;
    logic             rst   = 1'b0;
    logic             start = 1'b0;
    logic             stop  = 1'b0;
    logic             step  = 1'b0;
    logic [DIV_W-1:0] div   = '0;
    logic [LEN_W-1:0] len   = '0;
    logic             cnt_clr, cnt_en, busy, done;
    logic [1:0]       state;
    logic [LEN_W-1:0] pulses;
    logic [VW-1:0]    obs;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode 0 idle, 1 run, 2 pause, 3 done.
    // m_wait = RUN edges still needed before the next enable fires.
    int m_mode  = 0;
    int m_count = 0;
    int m_wait  = 1;
    int m_div   = 0;
    int m_len   = 0;
    bit m_clr   = 1'b0;
    bit m_en    = 1'b0;

    always #5 clk = ~clk;

    count_sequencer #(.DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .step    (step),
        .div     (div),
        .len     (len),
        .cnt_clr (cnt_clr),
        .cnt_en  (cnt_en),
        .busy    (busy),
        .done    (done),
        .state   (state),
        .pulses  (pulses)
    );

    assign obs = {cnt_clr, cnt_en, busy, done, state, pulses};

    function automatic logic [VW-1:0] expect_vec();
        logic [1:0] st;
        st = 2'(m_mode);
        return {m_clr, m_en, (m_mode == 1 || m_mode == 2), (m_mode == 3), st, LEN_W'(m_count)};
    endfunction

    function automatic void model_pulse();
        m_en    = 1'b1;
        m_count = (m_count + 1) % (1 << LEN_W);
        if (m_len != 0 && m_count == m_len) m_mode = 3;
    endfunction

    function automatic void model_begin();
        m_div   = int'(div);
        m_len   = int'(len);
        m_count = 0;
        m_wait  = m_div + 1;
        m_clr   = 1'b1;
        m_mode  = 1;
    endfunction

    function automatic void model_step();
        m_clr = 1'b0;
        m_en  = 1'b0;
        if (!rst) begin
            m_mode = 0; m_count = 0; m_div = 0; m_len = 0; m_wait = 1;
        end else begin
            case (m_mode)
                0: if (start) model_begin();
                1: begin
                    if (stop) m_mode = 2;
                    else if (m_wait == 1) begin
                        m_wait = m_div + 1;
                        model_pulse();
                    end else m_wait = m_wait - 1;
                end
                2: begin
                    if (stop) m_mode = 0;
                    else if (start) m_mode = 1;
                    else if (step) model_pulse();
                end
                default: begin
                    if (stop) m_mode = 0;
                    else if (start) model_begin();
                end
            endcase
        end
    endfunction

    // One clock: model consumes the same inputs the DUT sees at the edge,
    // outputs are then sampled 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1;
        div = 4'($urandom); len = 8'($urandom);
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++;
            if (obs !== '0) begin
                n_bad++;
                $display("FAIL reset_hold: got %h want %h", obs, {VW{1'b0}});
            end
        end
        rst = 1'b1; start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            stop = 1'($urandom); step = 1'($urandom);
            cycle();
            n_cmp++;
            if (obs !== expect_vec()) begin
                n_bad++;
                $display("FAIL idle_quiet: got %h want %h", obs, expect_vec());
            end
        end
        stop = 1'b0; step = 1'b0;
    endtask

    task automatic test_basic_run();
        int en_at[$];
        int want[4] = '{3, 6, 9, 12};
        int n_clr = 0;
        int clr_at = -1;
        div = 4'd2; len = 8'd4; start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cycle();
            start = 1'b0;
            n_cmp++;
            if (obs !== expect_vec()) begin
                n_bad++;
                $display("FAIL basic_run cyc %0d: got %h want %h", i, obs, expect_vec());
            end
            if (cnt_clr) begin n_clr++; clr_at = i; end
            if (cnt_en) en_at.push_back(i);
        end
        n_cmp++;
        if (n_clr != 1 || clr_at != 0) begin
            n_bad++;
            $display("FAIL basic_clr: got count %0d at %0d want 1 at 0", n_clr, clr_at);
        end
        n_cmp++;
        if (en_at.size() != 4) begin
            n_bad++;
            $display("FAIL basic_en_count: got %0d want 4", en_at.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (en_at[k] != want[k]) begin
                    n_bad++;
                    $display("FAIL basic_en_pos %0d: got %0d want %0d", k, en_at[k], want[k]);
                end
            end
        end
        n_cmp++;
        if ({done, state, pulses} !== {1'b1, 2'b11, 8'd4}) begin
            n_bad++;
            $display("FAIL basic_done: got %b %b %0d want 1 11 4", done, state, pulses);
        end
        stop = 1'b1; cycle(); stop = 1'b0;
        n_cmp++;
        if (obs !== expect_vec()) begin
            n_bad++;
            $display("FAIL basic_abort: got %h want %h", obs, expect_vec());
        end
    endtask

    task automatic test_pause_step();
        int guard = 0;
        int r;
        int gap = -1;
        div = 4'd3; len = 8'd0; start = 1'b1;
        cycle(); start = 1'b0;
        while (pulses !== 8'd2 && guard < 40) begin
            cycle(); guard++;
            n_cmp++;
            if (obs !== expect_vec()) begin
                n_bad++;
                $display("FAIL pause_run: got %h want %h", obs, expect_vec());
            end
        end
        n_cmp++;
        if (guard >= 40) begin
            n_bad++;
            $display("FAIL pause_timeout: got pulses %0d want 2", pulses);
        end
        r = $urandom_range(0, 2);
        for (int i = 0; i < r; i++) cycle();
        stop = 1'b1; cycle(); stop = 1'b0;
        n_cmp++;
        if ({state, cnt_en, pulses} !== {2'b10, 1'b0, 8'd2}) begin
            n_bad++;
            $display("FAIL pause_enter: got %b %b %0d want 10 0 2", state, cnt_en, pulses);
        end
        repeat ($urandom_range(1, 4)) cycle();
        step = 1'b1; cycle(); step = 1'b0;
        n_cmp++;
        if ({cnt_en, state, pulses} !== {1'b1, 2'b10, 8'd3}) begin
            n_bad++;
            $display("FAIL pause_step: got %b %b %0d want 1 10 3", cnt_en, state, pulses);
        end
        cycle();
        n_cmp++;
        if (obs !== expect_vec()) begin
            n_bad++;
            $display("FAIL pause_after_step: got %h want %h", obs, expect_vec());
        end
        start = 1'b1; cycle(); start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            n_cmp++;
            if (obs !== expect_vec()) begin
                n_bad++;
                $display("FAIL resume cyc %0d: got %h want %h", i, obs, expect_vec());
            end
            if (cnt_en && gap < 0) gap = i;
        end
        n_cmp++;
        if (gap != 4 - r) begin
            n_bad++;
            $display("FAIL resume_phase: got %0d want %0d", gap, 4 - r);
        end
        stop = 1'b1; cycle(); cycle(); stop = 1'b0;
    endtask

    task automatic test_priority_abort();
        int held;
        div = 4'($urandom_range(1, 5)); len = 8'd0; start = 1'b1;
        cycle(); start = 1'b0;
        repeat ($urandom_range(5, 20)) begin
            step = 1'($urandom);
            cycle();
            n_cmp++;
            if (obs !== expect_vec()) begin
                n_bad++;
                $display("FAIL run_step_ignored: got %h want %h", obs, expect_vec());
            end
        end
        step = 1'b0;
        start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
        n_cmp++;
        if ({state, cnt_en, busy} !== {2'b10, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL start_stop_prio: got %b %b %b want 10 0 1", state, cnt_en, busy);
        end
        held = m_count;
        stop = 1'b1; cycle(); stop = 1'b0;
        n_cmp++;
        if ({state, busy, done, pulses} !== {2'b00, 1'b0, 1'b0, LEN_W'(held)}) begin
            n_bad++;
            $display("FAIL abort_pause: got %b %b %b %0d want 00 0 0 %0d", state, busy, done, pulses, held);
        end
        for (int i = 0; i < 5; i++) begin
            step = 1'b1; cycle();
            n_cmp++;
            if (cnt_en !== 1'b0 || obs !== expect_vec()) begin
                n_bad++;
                $display("FAIL idle_step: got %h want %h", obs, expect_vec());
            end
        end
        step = 1'b0;
    endtask

    task automatic test_edge_cases();
        int guard = 0;
        int lenv;
        div = 4'd0; len = 8'd0; start = 1'b1;
        cycle(); start = 1'b0;
        for (int i = 1; i <= 260; i++) begin
            cycle();
            n_cmp++;
            if (cnt_en !== 1'b1 || pulses !== 8'(i) || obs !== expect_vec()) begin
                n_bad++;
                $display("FAIL freerun_wrap cyc %0d: got en %b pulses %0d want en 1 pulses %0d", i, cnt_en, pulses, i % 256);
            end
        end
        stop = 1'b1; cycle(); cycle(); stop = 1'b0;
        div = 4'($urandom); len = 8'($urandom_range(2, 10)); start = 1'b1;
        lenv = int'(len);
        cycle(); start = 1'b0;
        while (pulses !== LEN_W'(lenv - 1) && guard < 250) begin
            cycle(); guard++;
            n_cmp++;
            if (obs !== expect_vec()) begin
                n_bad++;
                $display("FAIL step_done_run: got %h want %h", obs, expect_vec());
            end
        end
        n_cmp++;
        if (guard >= 250) begin
            n_bad++;
            $display("FAIL step_done_timeout: got pulses %0d want %0d", pulses, lenv - 1);
        end
        stop = 1'b1; cycle(); stop = 1'b0;
        step = 1'b1; cycle(); step = 1'b0;
        n_cmp++;
        if ({cnt_en, done, state, pulses} !== {1'b1, 1'b1, 2'b11, LEN_W'(lenv)}) begin
            n_bad++;
            $display("FAIL step_to_done: got %b %b %b %0d want 1 1 11 %0d", cnt_en, done, state, pulses, lenv);
        end
        cycle();
        n_cmp++;
        if (obs !== expect_vec()) begin
            n_bad++;
            $display("FAIL done_hold: got %h want %h", obs, expect_vec());
        end
        stop = 1'b1; cycle(); stop = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int guard = 0;
        int en_at[$];
        int want[3] = '{2, 4, 6};
        div = 4'd2; len = 8'd0; start = 1'b1;
        cycle(); start = 1'b0;
        repeat ($urandom_range(3, 10)) cycle();
        while (!(m_mode == 1 && m_wait == 1) && guard < 20) begin cycle(); guard++; end
        n_cmp++;
        if (guard >= 20) begin
            n_bad++;
            $display("FAIL rst_mid_timeout: got state %b want 01", state);
        end
        rst = 1'b0; cycle(); rst = 1'b1;
        n_cmp++;
        if (obs !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_run: got %h want %h", obs, {VW{1'b0}});
        end
        cycle();
        n_cmp++;
        if (obs !== expect_vec()) begin
            n_bad++;
            $display("FAIL rst_mid_after: got %h want %h", obs, expect_vec());
        end
        div = 4'd1; len = 8'd3; start = 1'b1;
        for (int i = 0; i < 11; i++) begin
            cycle();
            start = 1'b0;
            div = 4'($urandom); len = 8'($urandom);
            n_cmp++;
            if (obs !== expect_vec()) begin
                n_bad++;
                $display("FAIL latch_hold cyc %0d: got %h want %h", i, obs, expect_vec());
            end
            if (cnt_en) en_at.push_back(i);
        end
        n_cmp++;
        if (en_at.size() != 3) begin
            n_bad++;
            $display("FAIL latch_en_count: got %0d want 3", en_at.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (en_at[k] != want[k]) begin
                    n_bad++;
                    $display("FAIL latch_en_pos %0d: got %0d want %0d", k, en_at[k], want[k]);
                end
            end
        end
        n_cmp++;
        if ({state, pulses} !== {2'b11, 8'd3}) begin
            n_bad++;
            $display("FAIL latch_len: got %b %0d want 11 3", state, pulses);
        end
        stop = 1'b1; cycle(); stop = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) != 0);
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 14) == 0);
            step  = ($urandom_range(0, 5) == 0);
            div   = 4'($urandom_range(0, 3));
            len   = 8'($urandom_range(0, 6));
            cycle();
            n_cmp++;
            if (obs !== expect_vec()) begin
                n_bad++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs, expect_vec());
            end
            n_cmp++;
            if (cnt_clr && cnt_en) begin
                n_bad++;
                $display("FAIL clr_en_overlap cyc %0d: got both high want exclusive", i);
            end
        end
        rst = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_pause_step();
        test_priority_abort();
        test_edge_cases();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
